// File: rtl/alu8_pkg.sv
// alu8_pkg: opcode encodings and flag bit positions shared by the alu8 slice.
// No ports. Optional feature macro used by alu8: ALU8_SHIFT_EN.
package alu8_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBC  = 4'h3;
  localparam logic [3:0] OP_CP   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_RL   = 4'h8;
  localparam logic [3:0] OP_RR   = 4'h9;
  localparam logic [3:0] OP_BSL  = 4'hA;
  localparam logic [3:0] OP_BSR  = 4'hB;
  localparam logic [3:0] OP_SWAP = 4'hC;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

endpackage

// File: rtl/alu8_addsub.sv
// alu8_addsub: 9-bit adder/subtractor shared by ADD, ADC, SUB, SBC and CP.
// Ports:
//   a, b   : 8-bit operands
//   cin    : carry in (add) or borrow in (subtract)
//   sub    : 1 = a - b - cin, 0 = a + b + cin
//   sum    : low 8 bits of the result
//   half   : carry out of bit 3 (add) / borrow out of bit 3 (subtract)
//   carry  : bit 8 of the result; for subtract this is the borrow
module alu8_addsub (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [7:0] sum,
  output logic       half,
  output logic       carry
);

  logic [8:0] full;
  logic [4:0] nib;

  // Zero-extended arithmetic: for subtract, a negative result wraps so the
  // top bit of each width is exactly the borrow.
  always_comb begin
    if (sub) begin
      full = {1'b0, a} - {1'b0, b} - {8'b0, cin};
      nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, cin};
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'b0, cin};
      nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    end
    sum   = full[7:0];
    half  = nib[4];
    carry = full[8];
  end

endmodule

// File: rtl/alu8.sv
// alu8: 8-bit ALU with combinational result/flags and a registered copy.
// Ports:
//   clk      : clock, outputs registered on rising edge
//   rst_n    : asynchronous active-low reset (clears resQ/flagsQ only)
//   regA     : operand A, also rotate/shift/swap source
//   regB     : operand B
//   opcode   : operation select (see alu8_pkg)
//   carryIn  : carry/borrow for ADC/SBC, shifted-in bit for RL/RR
//   res      : combinational result
//   flagsOut : combinational flags {Z,N,H,C,4'b0}
//   resQ     : res registered
//   flagsQ   : flagsOut registered
// Build option: define ALU8_SHIFT_EN to enable BSL, BSR and SWAP; without it
// those opcodes fall into the undefined-opcode behaviour.
module alu8
  import alu8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] regA,
  input  logic [7:0] regB,
  input  logic [3:0] opcode,
  input  logic       carryIn,
  output logic [7:0] res,
  output logic [7:0] flagsOut,
  output logic [7:0] resQ,
  output logic [7:0] flagsQ
);

  logic       as_cin;
  logic       as_sub;
  logic [7:0] as_sum;
  logic       as_half;
  logic       as_carry;

  // CP compares exactly like SUB, so it uses no carry-in.
  assign as_sub = (opcode == OP_SUB) || (opcode == OP_SBC) || (opcode == OP_CP);
  assign as_cin = ((opcode == OP_ADC) || (opcode == OP_SBC)) ? carryIn : 1'b0;

  alu8_addsub u_addsub (
    .a     (regA),
    .b     (regB),
    .cin   (as_cin),
    .sub   (as_sub),
    .sum   (as_sum),
    .half  (as_half),
    .carry (as_carry)
  );

  logic fz, fn, fh, fc;
  logic undef_op;

  always_comb begin
    res      = regA;
    fn       = 1'b0;
    fh       = 1'b0;
    fc       = 1'b0;
    undef_op = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC: begin
        res = as_sum;
        fh  = as_half;
        fc  = as_carry;
      end
      OP_SUB, OP_SBC: begin
        res = as_sum;
        fn  = 1'b1;
        fh  = as_half;
        fc  = as_carry;
      end
      OP_CP: begin
        res = regA;
        fn  = 1'b1;
        fh  = as_half;
        fc  = as_carry;
      end
      OP_AND: begin
        res = regA & regB;
        fh  = 1'b1;
      end
      OP_OR:  res = regA | regB;
      OP_XOR: res = regA ^ regB;
      OP_RL: begin
        res = {regA[6:0], carryIn};
        fc  = regA[7];
      end
      OP_RR: begin
        res = {carryIn, regA[7:1]};
        fc  = regA[0];
      end
`ifdef ALU8_SHIFT_EN
      OP_BSL: begin
        res = {regA[6:0], 1'b0};
        fc  = regA[7];
      end
      OP_BSR: begin
        res = {1'b0, regA[7:1]};
        fc  = regA[0];
      end
      OP_SWAP: res = {regA[3:0], regA[7:4]};
`endif
      default: begin
        res      = regA;
        undef_op = 1'b1;
      end
    endcase

    // CP returns A, so zero must come from the comparison, not from res.
    fz = (opcode == OP_CP) ? (regA == regB) : (res == 8'h00);

    flagsOut = 8'h00;
    if (!undef_op) begin
      flagsOut[FLAG_Z] = fz;
      flagsOut[FLAG_N] = fn;
      flagsOut[FLAG_H] = fh;
      flagsOut[FLAG_C] = fc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resQ   <= 8'h00;
      flagsQ <= 8'h00;
    end else begin
      resQ   <= res;
      flagsQ <= flagsOut;
    end
  end

endmodule

// File: tb/tb_alu8.sv
module tb_alu8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] regA, regB;
  logic [3:0] opcode;
  logic       carryIn;
  logic [7:0] res, flagsOut, resQ, flagsQ;

  int n_vec = 0;
  int n_miss = 0;
  logic [15:0] sb_q[$];

  alu8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .regA     (regA),
    .regB     (regB),
    .opcode   (opcode),
    .carryIn  (carryIn),
    .res      (res),
    .flagsOut (flagsOut),
    .resQ     (resQ),
    .flagsQ   (flagsQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %02h expected %02h (op=%h a=%02h b=%02h ci=%0b)",
               tag, obs, exp, opcode, regA, regB, carryIn);
    end
  endtask

  // Reference model written from the operation definitions with integer math.
  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    int ia, ib, ic, s;
    logic [7:0] r;
    logic z, n, h, c;
    ia = int'(a); ib = int'(b); ic = 0;
    n = 0; h = 0; c = 0;
    r = a;
    case (op)
      4'h0, 4'h1: begin
        if (op == 4'h1) ic = int'(ci);
        s = ia + ib + ic;
        r = 8'(s);
        h = ((ia % 16) + (ib % 16) + ic) > 15;
        c = s > 255;
      end
      4'h2, 4'h3, 4'h4: begin
        if (op == 4'h3) ic = int'(ci);
        s = ia - ib - ic;
        r = (op == 4'h4) ? a : 8'(s + 256);
        n = 1;
        h = (ia % 16) < ((ib % 16) + ic);
        c = ia < (ib + ic);
      end
      4'h5: begin r = a & b; h = 1; end
      4'h6: r = a | b;
      4'h7: r = a ^ b;
      4'h8: begin r = 8'((ia * 2) % 256 + int'(ci)); c = ia >= 128; end
      4'h9: begin r = 8'(ia / 2 + 128 * int'(ci)); c = (ia % 2) == 1; end
`ifdef ALU8_SHIFT_EN
      4'hA: begin r = 8'((ia * 2) % 256); c = ia >= 128; end
      4'hB: begin r = 8'(ia / 2); c = (ia % 2) == 1; end
      4'hC: r = 8'((ia % 16) * 16 + ia / 16);
`endif
      default: return {a, 8'h00};
    endcase
    z = (op == 4'h4) ? (a == b) : (r == 8'h00);
    return {r, z, n, h, c, 4'b0000};
  endfunction

  // Drive at negedge, check combinational outputs, push the expectation,
  // then check the registered copy one rising edge later.
  task automatic apply(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [15:0] exp_fixed, input bit use_fixed);
    logic [15:0] e, q;
    @(negedge clk);
    opcode = op; regA = a; regB = b; carryIn = ci;
    #1;
    e = use_fixed ? exp_fixed : model(op, a, b, ci);
    check("res", res, e[15:8]);
    check("flagsOut", flagsOut, e[7:0]);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_miss++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      q = sb_q.pop_front();
      check("resQ", resQ, q[15:8]);
      check("flagsQ", flagsQ, q[7:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    regA = 8'h5A; regB = 8'h00; opcode = 4'h0; carryIn = 1'b0;
    #2;
    check("rst_resQ", resQ, 8'h00);
    check("rst_flagsQ", flagsQ, 8'h00);
    check("rst_res_live", res, 8'h5A);
    @(posedge clk);
    #1;
    check("rst_hold_resQ", resQ, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations.
    apply(4'h0, 8'hFF, 8'h01, 1'b0, {8'h00, 8'hB0}, 1);
    apply(4'h1, 8'h0F, 8'h01, 1'b1, {8'h11, 8'h20}, 1);
    apply(4'h3, 8'h10, 8'h0F, 1'b1, {8'h00, 8'hE0}, 1);
    apply(4'h4, 8'h3C, 8'h3C, 1'b1, {8'h3C, 8'hC0}, 1);
    apply(4'h8, 8'h80, 8'h00, 1'b1, {8'h01, 8'h10}, 1);
    apply(4'h9, 8'h01, 8'h00, 1'b0, {8'h00, 8'h90}, 1);
`ifdef ALU8_SHIFT_EN
    apply(4'hC, 8'hF0, 8'h00, 1'b0, {8'h0F, 8'h00}, 1);
    apply(4'hA, 8'h81, 8'h00, 1'b1, {8'h02, 8'h10}, 1);
    apply(4'hB, 8'h81, 8'h00, 1'b1, {8'h40, 8'h10}, 1);
`else
    apply(4'hC, 8'hF0, 8'h00, 1'b0, {8'hF0, 8'h00}, 1);
    apply(4'hA, 8'h81, 8'h00, 1'b1, {8'h81, 8'h00}, 1);
    apply(4'hB, 8'h81, 8'h00, 1'b1, {8'h81, 8'h00}, 1);
`endif
    apply(4'h2, 8'h00, 8'h01, 1'b1, {8'hFF, 8'h70}, 1);
    apply(4'h5, 8'hF0, 8'h0F, 1'b0, {8'h00, 8'hA0}, 1);
    apply(4'h6, 8'h00, 8'h00, 1'b1, {8'h00, 8'h80}, 1);
    apply(4'h7, 8'hAA, 8'h55, 1'b0, {8'hFF, 8'h00}, 1);
    apply(4'hF, 8'h00, 8'h33, 1'b1, {8'h00, 8'h00}, 1);
    apply(4'h4, 8'h10, 8'h20, 1'b0, {8'h10, 8'h50}, 1);

    // Mid-stream reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_resQ", resQ, 8'h00);
    check("midrst_flagsQ", flagsQ, 8'h00);
    check("midrst_res_live", res, 8'h10);
    check("midrst_flags_live", flagsOut, 8'h50);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'h0, 8'h12, 8'h34, 1'b0, {8'h46, 8'h00}, 1);

    // Random sweep against the model.
    for (int i = 0; i < 300; i++) begin
      apply(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 16'h0000, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu8.md
ALU8 -- requirements
Module: alu8

Interface
REQ-001 SHALL expose: clk  input  1  single clock; rising edge samples the registered outputs.
REQ-002 SHALL expose: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL expose: regA  input  8  operand A; also the rotate/shift/swap source.
REQ-004 SHALL expose: regB  input  8  operand B; ignored by RL, RR, BSL, BSR and SWAP.
REQ-005 SHALL expose: opcode  input  4  operation select, encoded per REQ-011.
REQ-006 SHALL expose: carryIn  input  1  carry/borrow into ADC and SBC; bit shifted in by RL and RR.
REQ-007 SHALL expose: res  output  8  combinational result.
REQ-008 SHALL expose: flagsOut  output  8  combinational flags: [7]=Z, [6]=N, [5]=H, [4]=C, [3:0]=0.
REQ-009 SHALL expose: resQ  output  8  res registered on the rising edge of clk.
REQ-010 SHALL expose: flagsQ  output  8  flagsOut registered on the rising edge of clk.

Function
REQ-011 SHALL decode the opcodes as follows: ADD=0, ADC=1, SUB=2, SBC=3, CP=4, AND=5, OR=6, XOR=7, RL=8, RR=9, BSL=A, BSR=B, SWAP=C; codes D-F are undefined.
REQ-012 SHALL make res and flagsOut purely combinational (zero latency); they SHALL settle within the same cycle as an input change.
REQ-013 SHALL compute ADD/ADC with 9-bit arithmetic: res = A+B+cin, where cin=0 for ADD; N=0; H=carry out of bit 3; C=bit 8 of the sum.
REQ-014 SHALL compute SUB/SBC as res = A-B-cin modulo 256, where cin=0 for SUB; N=1; H=1 iff A[3:0] < B[3:0]+cin; C=1 iff A < B+cin, evaluated at 9 bits.
REQ-015 SHALL make CP set flags exactly as SUB and return res = regA unchanged.
REQ-016 SHALL set AND flags as N=0, H=1, C=0, and OR/XOR flags as N=0, H=0, C=0.
REQ-017 SHALL compute RL as res={A[6:0],carryIn} with C=A[7], and RR as res={carryIn,A[7:1]} with C=A[0]; N=0 and H=0 for both.
REQ-018 SHALL compute BSL as res={A[6:0],0} with C=A[7], and BSR (logical) as res={0,A[7:1]} with C=A[0]; N=0 and H=0 for both.
REQ-019 SHALL compute SWAP as res={A[3:0],A[7:4]} with N=0, H=0, C=0.
REQ-020 SHALL set Z=1 iff res==0x00 for every defined opcode except CP, where Z=1 iff A==B.
REQ-021 SHALL, for an undefined opcode, drive res=regA and flagsOut=0x00.
REQ-022 SHALL always drive flagsOut[3:0]=0.
REQ-023 SHALL capture res and flagsOut into resQ and flagsQ on every rising edge of clk while rst_n=1, giving one-cycle latency with no enable.

Reset
REQ-024 SHALL clear resQ and flagsQ to 0x00 immediately whenever rst_n=0, independent of clk.
REQ-025 SHALL leave res and flagsOut unaffected by reset (they follow the inputs at all times).
REQ-026 SHALL, after rst_n deasserts, capture on the first rising edge of clk.

Configuration
REQ-027 SHALL implement BSL, BSR and SWAP only when ALU8_SHIFT_EN is defined; otherwise opcodes A-C SHALL behave as undefined per REQ-021.

Structure
REQ-028 SHALL place the opcode constants and the flag bit indices (Z=7, N=6, H=5, C=4) in shared package alu8_pkg.
REQ-029 SHALL instantiate one sub-module, alu8_addsub, a 9-bit adder/subtractor producing half-carry and carry, used by ADD, ADC, SUB, SBC and CP.

Verification
REQ-030 SHALL cover ADD with A=0xFF, B=0x01 -> res=0x00, flagsOut=0xB0.
REQ-031 SHALL cover ADC with A=0x0F, B=0x01, cin=1 -> res=0x11, flagsOut=0x20.
REQ-032 SHALL cover SBC with A=0x10, B=0x0F, cin=1 -> res=0x00, flagsOut=0xE0; and CP with A=B=0x3C -> res=0x3C, flagsOut=0xC0.
REQ-033 SHALL cover RL with A=0x80, cin=1 -> res=0x01, flagsOut=0x10; and RR with A=0x01, cin=0 -> res=0x00, flagsOut=0x90.
REQ-034 SHALL cover SWAP with A=0xF0 -> res=0x0F, flagsOut=0x00 (with ALU8_SHIFT_EN); without the macro -> res=0xF0, flagsOut=0x00.
REQ-035 SHALL cover reset: assert rst_n=0 mid-stream -> resQ and flagsQ read 0x00 before the next clk edge; after release -> resQ equals the prior-cycle res one edge later.
